// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard producing stall/bubble/flush beside decode.
// Optional HAZARD_PERF_EN adds saturating stall/flush event counters.
module hazard_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = 5,
  parameter int LD_LAT   = 1,
  parameter int CW       = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [REG_AW-1:0]   id_rs1,
  input  logic [REG_AW-1:0]   id_rs2,
  input  logic                id_use_rs1,
  input  logic                id_use_rs2,
  input  logic                id_early,
  input  logic [REG_AW-1:0]   id_rd,
  input  logic                id_wr,
  input  logic                id_is_load,
  input  logic                redirect,
  input  logic                mem_stall,
  output logic                stall,
  output logic                bubble,
  output logic                flush,
  output logic [NUM_REGS-1:0] busy_vec
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]         perf_lu_stall,
  output logic [31:0]         perf_br_stall,
  output logic [31:0]         perf_flush
`endif
);

  localparam logic [CW-1:0] LD_CNT  = CW'(LD_LAT + 1);
  localparam logic [CW-1:0] ALU_CNT = CW'(1);

  logic [CW-1:0] r_cnt [NUM_REGS];

  logic [CW-1:0] w_cnt_rs1;
  logic [CW-1:0] w_cnt_rs2;
  logic          w_busy_n1;
  logic          w_busy_n2;
  logic          w_busy_e1;
  logic          w_busy_e2;
  logic          w_hz;
  logic          w_issue;
  logic          w_record;

  assign w_cnt_rs1 = r_cnt[id_rs1];
  assign w_cnt_rs2 = r_cnt[id_rs2];

  // A count of 1 means the producer is in EX: forwardable to EX, not to ID.
  assign w_busy_n1 = id_use_rs1 & (id_rs1 != '0) & (w_cnt_rs1 > ALU_CNT);
  assign w_busy_n2 = id_use_rs2 & (id_rs2 != '0) & (w_cnt_rs2 > ALU_CNT);
  assign w_busy_e1 = id_use_rs1 & (id_rs1 != '0) & (w_cnt_rs1 != '0);
  assign w_busy_e2 = id_use_rs2 & (id_rs2 != '0) & (w_cnt_rs2 != '0);

  assign w_hz     = id_valid & (id_early ? (w_busy_e1 | w_busy_e2)
                                         : (w_busy_n1 | w_busy_n2));
  assign w_issue  = id_valid & ~mem_stall & ~redirect & ~w_hz;
  assign w_record = w_issue & id_wr & (id_rd != '0);

  // Issue write overrides the decrement so the youngest producer wins (WAW).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_cnt[i] <= '0;
    end else if (!mem_stall) begin
      r_cnt[0] <= '0;
      for (int i = 1; i < NUM_REGS; i++) begin
        if (w_record && (id_rd == REG_AW'(i)))
          r_cnt[i] <= id_is_load ? LD_CNT : ALU_CNT;
        else if (r_cnt[i] != '0)
          r_cnt[i] <= r_cnt[i] - ALU_CNT;
      end
    end
  end

  always_comb begin
    busy_vec = '0;
    for (int i = 0; i < NUM_REGS; i++) busy_vec[i] = (r_cnt[i] != '0);
  end

  // Priority: frozen pipeline, then redirect kill, then data hazard.
  always_comb begin
    stall  = 1'b0;
    bubble = 1'b0;
    flush  = 1'b0;
    if (mem_stall) begin
      stall = 1'b1;
    end else if (redirect) begin
      flush  = 1'b1;
      bubble = 1'b1;
    end else if (w_hz) begin
      stall  = 1'b1;
      bubble = 1'b1;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] r_perf_lu;
  logic [31:0] r_perf_br;
  logic [31:0] r_perf_fl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_lu <= '0;
      r_perf_br <= '0;
      r_perf_fl <= '0;
    end else if (!mem_stall) begin
      if (w_hz && !id_early && !redirect && (r_perf_lu != '1))
        r_perf_lu <= r_perf_lu + 32'd1;
      if (w_hz && id_early && !redirect && (r_perf_br != '1))
        r_perf_br <= r_perf_br + 32'd1;
      if (redirect && (r_perf_fl != '1))
        r_perf_fl <= r_perf_fl + 32'd1;
    end
  end

  assign perf_lu_stall = r_perf_lu;
  assign perf_br_stall = r_perf_br;
  assign perf_flush    = r_perf_fl;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: two instances (LD_LAT=1 and LD_LAT=3)
// share one decode-stage stimulus; outputs are checked at the falling edge.
module tb_hazard_scoreboard;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic        id_early;
  logic [4:0]  id_rd;
  logic        id_wr;
  logic        id_is_load;
  logic        redirect;
  logic        mem_stall;

  logic        stall1, bubble1, flush1;
  logic        stall3, bubble3, flush3;
  logic [31:0] busy1;
  logic [31:0] busy3;
  logic [2:0]  o1;
  logic [2:0]  o3;

  int n_chk;
  int n_pass;

  assign o1 = {stall1, bubble1, flush1};
  assign o3 = {stall3, bubble3, flush3};

`ifdef HAZARD_PERF_EN
  logic [31:0] plu1, pbr1, pfl1;
  logic [31:0] plu3, pbr3, pfl3;
`endif

  hazard_scoreboard #(.NUM_REGS(32), .REG_AW(5), .LD_LAT(1), .CW(3)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_early(id_early), .id_rd(id_rd), .id_wr(id_wr), .id_is_load(id_is_load),
    .redirect(redirect), .mem_stall(mem_stall),
    .stall(stall1), .bubble(bubble1), .flush(flush1), .busy_vec(busy1)
`ifdef HAZARD_PERF_EN
    , .perf_lu_stall(plu1), .perf_br_stall(pbr1), .perf_flush(pfl1)
`endif
  );

  hazard_scoreboard #(.NUM_REGS(32), .REG_AW(5), .LD_LAT(3), .CW(3)) u_lat3 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_early(id_early), .id_rd(id_rd), .id_wr(id_wr), .id_is_load(id_is_load),
    .redirect(redirect), .mem_stall(mem_stall),
    .stall(stall3), .bubble(bubble3), .flush(flush3), .busy_vec(busy3)
`ifdef HAZARD_PERF_EN
    , .perf_lu_stall(plu3), .perf_br_stall(pbr3), .perf_flush(pfl3)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_early = 0; id_rd = 0; id_wr = 0; id_is_load = 0;
    redirect = 0; mem_stall = 0;
  endtask

  task automatic idle(input int n);
    clear();
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic ins_load(input logic [4:0] rd, input logic [4:0] rs1);
    clear();
    id_valid = 1; id_rd = rd; id_wr = 1; id_is_load = 1;
    id_rs1 = rs1; id_use_rs1 = 1;
  endtask

  task automatic ins_alu(input logic [4:0] rd, input logic [4:0] rs1, input logic wr);
    clear();
    id_valid = 1; id_rd = rd; id_wr = wr; id_rs1 = rs1; id_use_rs1 = (rs1 != 0);
  endtask

  task automatic ins_branch(input logic [4:0] rs1, input logic [4:0] rs2);
    clear();
    id_valid = 1; id_early = 1; id_rs1 = rs1; id_rs2 = rs2;
    id_use_rs1 = 1; id_use_rs2 = 1;
  endtask

  // Scenarios
  task automatic test_reset();
    @(negedge clk);
    n_chk++;
    if ({o1, o3} !== 6'b0) $display("FAIL reset_outs got %b exp 000000", {o1, o3});
    else n_pass++;
    n_chk++;
    if ({busy1, busy3} !== 64'b0) $display("FAIL reset_busy got %h exp 0", {busy1, busy3});
    else n_pass++;
  endtask

  task automatic test_load_use();
`ifdef HAZARD_PERF_EN
    logic [31:0] p0;
`endif
    idle(6);
`ifdef HAZARD_PERF_EN
    p0 = plu1;
`endif
    ins_load(5'd5, 5'd0);
    @(negedge clk);
    n_chk++;
    if (o1 !== 3'b000) $display("FAIL lu_load_issue got %b exp 000", o1); else n_pass++;
    tick();
    ins_alu(5'd6, 5'd5, 1'b0);
    @(negedge clk);
    n_chk++;
    if (o1 !== 3'b110) $display("FAIL lu_stall got %b exp 110", o1); else n_pass++;
    tick();
    @(negedge clk);
    n_chk++;
    if (o1 !== 3'b000) $display("FAIL lu_issue got %b exp 000", o1); else n_pass++;
    tick();
    clear();
`ifdef HAZARD_PERF_EN
    n_chk++;
    if (plu1 !== p0 + 32'd1) $display("FAIL perf_lu got %0d exp %0d", plu1, p0 + 32'd1);
    else n_pass++;
`endif
  endtask

  task automatic test_branch();
`ifdef HAZARD_PERF_EN
    logic [31:0] p0;
`endif
    idle(6);
`ifdef HAZARD_PERF_EN
    p0 = pbr1;
`endif
    ins_load(5'd5, 5'd0);
    tick();
    ins_branch(5'd5, 5'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_chk++;
      if (o1 !== 3'b110) $display("FAIL br_ld_stall%0d got %b exp 110", i, o1); else n_pass++;
      tick();
    end
    @(negedge clk);
    n_chk++;
    if (o1 !== 3'b000) $display("FAIL br_ld_issue got %b exp 000", o1); else n_pass++;
    tick();
`ifdef HAZARD_PERF_EN
    n_chk++;
    if (pbr1 !== p0 + 32'd2) $display("FAIL perf_br got %0d exp %0d", pbr1, p0 + 32'd2);
    else n_pass++;
`endif
    idle(6);
    ins_alu(5'd6, 5'd0, 1'b1);
    tick();
    ins_branch(5'd0, 5'd6);
    @(negedge clk);
    n_chk++;
    if (o1 !== 3'b110) $display("FAIL br_alu_stall got %b exp 110", o1); else n_pass++;
    tick();
    @(negedge clk);
    n_chk++;
    if (o1 !== 3'b000) $display("FAIL br_alu_issue got %b exp 000", o1); else n_pass++;
    tick();
    ins_alu(5'd8, 5'd0, 1'b1);
    tick();
    ins_alu(5'd9, 5'd8, 1'b0);
    @(negedge clk);
    n_chk++;
    if (o1 !== 3'b000) $display("FAIL alu_alu_fwd got %b exp 000", o1); else n_pass++;
    tick();
    clear();
  endtask

  task automatic test_lat3();
    idle(6);
    ins_load(5'd7, 5'd0);
    tick();
    ins_alu(5'd0, 5'd7, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_chk++;
      if ({o3, busy3[7]} !== 4'b1101) $display("FAIL lat3_stall%0d got %b exp 1101", i, {o3, busy3[7]});
      else n_pass++;
      tick();
    end
    @(negedge clk);
    n_chk++;
    if ({o3, busy3[7]} !== 4'b0001) $display("FAIL lat3_issue got %b exp 0001", {o3, busy3[7]});
    else n_pass++;
    tick();
    clear();
    @(negedge clk);
    n_chk++;
    if (busy3[7] !== 1'b0) $display("FAIL lat3_busy_end got %b exp 0", busy3[7]); else n_pass++;
  endtask

  task automatic test_mem_stall();
    idle(6);
    ins_load(5'd5, 5'd0);
    tick();
    ins_alu(5'd0, 5'd5, 1'b0);
    mem_stall = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_chk++;
      if ({o1, busy1[5]} !== 4'b1001) $display("FAIL ms_hold%0d got %b exp 1001", i, {o1, busy1[5]});
      else n_pass++;
      tick();
    end
    mem_stall = 0;
    @(negedge clk);
    n_chk++;
    if (o1 !== 3'b110) $display("FAIL ms_release_bubble got %b exp 110", o1); else n_pass++;
    tick();
    @(negedge clk);
    n_chk++;
    if (o1 !== 3'b000) $display("FAIL ms_release_issue got %b exp 000", o1); else n_pass++;
    tick();
    clear();
  endtask

  task automatic test_redirect();
`ifdef HAZARD_PERF_EN
    logic [31:0] p0;
`endif
    idle(6);
`ifdef HAZARD_PERF_EN
    p0 = pfl1;
`endif
    ins_load(5'd5, 5'd0);
    tick();
    ins_alu(5'd9, 5'd5, 1'b1);
    redirect = 1;
    @(negedge clk);
    n_chk++;
    if (o1 !== 3'b011) $display("FAIL redir_out got %b exp 011", o1); else n_pass++;
    tick();
    clear();
    @(negedge clk);
    n_chk++;
    if ({busy1[9], busy1[5]} !== 2'b01) $display("FAIL redir_nowrite got %b exp 01", {busy1[9], busy1[5]});
    else n_pass++;
`ifdef HAZARD_PERF_EN
    n_chk++;
    if (pfl1 !== p0 + 32'd1) $display("FAIL perf_flush got %0d exp %0d", pfl1, p0 + 32'd1);
    else n_pass++;
`endif
    idle(6);
    ins_load(5'd0, 5'd0);
    tick();
    ins_branch(5'd0, 5'd0);
    @(negedge clk);
    n_chk++;
    if ({o1, busy1} !== 35'b0) $display("FAIL x0_untracked got %b/%h exp 000/0", o1, busy1);
    else n_pass++;
    tick();
    clear();
  endtask

  task automatic test_waw_self();
    idle(6);
    ins_load(5'd7, 5'd7);
    @(negedge clk);
    n_chk++;
    if (o3 !== 3'b000) $display("FAIL self_dep got %b exp 000", o3); else n_pass++;
    tick();
    ins_alu(5'd7, 5'd0, 1'b1);
    tick();
    ins_alu(5'd0, 5'd7, 1'b0);
    @(negedge clk);
    n_chk++;
    if (o3 !== 3'b000) $display("FAIL waw_youngest got %b exp 000", o3); else n_pass++;
    tick();
    clear();
  endtask

  task automatic test_reset_mid();
    idle(6);
    ins_load(5'd5, 5'd0);
    tick();
    ins_alu(5'd0, 5'd5, 1'b0);
    @(negedge clk);
    n_chk++;
    if (o1 !== 3'b110) $display("FAIL rst_pre got %b exp 110", o1); else n_pass++;
    #1 rst_n = 0;
    #1;
    n_chk++;
    if ({o1, busy1} !== 35'b0) $display("FAIL rst_mid got %b/%h exp 000/0", o1, busy1);
    else n_pass++;
    redirect = 1;
    #1;
    n_chk++;
    if (o1 !== 3'b011) $display("FAIL rst_redir got %b exp 011", o1); else n_pass++;
    clear();
    tick();
    rst_n = 1;
    tick();
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    clear();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    test_reset();
    test_load_use();
    test_branch();
    test_lat3();
    test_mem_stall();
    test_redirect();
    test_waw_self();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised hazard unit for the 5-stage RISC-V core with L2 cache. Replaces fixed-compare load-use detection with a per-register countdown scoreboard.
- Supports configurable load-use latency for pipelined cache read paths and ID-stage operand consumers (branch/jalr), which need extra stall cycles.
- Produces stall, bubble and flush for the IF/ID and ID/EX registers; it sits beside the decode stage.

Parameters:
NUM_REGS, 32, architectural register count; entry 0 is never tracked
REG_AW, 5, register index width, equal to clog2(NUM_REGS)
LD_LAT, 1, load-use stall cycles seen by an EX-stage consumer (range 1..6)
CW, 3, countdown width; must satisfy 2^CW > LD_LAT+1

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  IF/ID holds a valid instruction
id_rs1  in  REG_AW  source 1 index
id_rs2  in  REG_AW  source 2 index
id_use_rs1  in  1  instruction reads rs1
id_use_rs2  in  1  instruction reads rs2
id_early  in  1  operands are consumed in ID (branch compare, jalr target)
id_rd  in  REG_AW  destination index
id_wr  in  1  instruction writes rd
id_is_load  in  1  instruction is a load
redirect  in  1  taken branch or jump resolved in ID; held by the source while mem_stall is high
mem_stall  in  1  I$/D$/L2 busy; the whole pipeline freezes
stall  out  1  hold PC and IF/ID
bubble  out  1  inject NOP into ID/EX
flush  out  1  clear IF/ID
busy_vec  out  NUM_REGS  bit r = cnt[r]!=0 (debug)

Behaviour:
- State: cnt[1..NUM_REGS-1], each CW bits wide. All entries reset to 0 asynchronously. cnt[0] is tied to 0.
- Operand match: src_busy_n(rs) = use & rs!=0 & cnt[rs]>1. src_busy_e(rs) = use & rs!=0 & cnt[rs]>0.
- Hazard: hz = id_valid & (id_early ? (src_busy_e(rs1)|src_busy_e(rs2)) : (src_busy_n(rs1)|src_busy_n(rs2))).
- Output priority, evaluated combinationally each cycle:
  - mem_stall=1: stall=1, bubble=0, flush=0. Counters hold. Nothing issues.
  - else redirect=1: flush=1, stall=0, bubble=1. The ID instruction is killed and is not recorded, even if hz=1 (redirect beats stall).
  - else hz=1: stall=1, bubble=1, flush=0.
  - else: all outputs 0. The instruction issues when id_valid=1.
- Issue: issue = id_valid & ~mem_stall & ~redirect & ~hz.
- Counter update, on clock edges with mem_stall=0:
  - Every nonzero cnt decrements by 1.
  - Then, if issue & id_wr & id_rd!=0: cnt[id_rd] <= id_is_load ? LD_LAT+1 : 1. The issue write overrides the decrement on that entry.
- Resulting latencies with LD_LAT=1:
  - Load, then dependent ALU op: 1 stall.
  - Load, then dependent branch/jalr: 2 stalls.
  - ALU op, then dependent branch: 1 stall.
  - ALU op, then dependent ALU op: 0 stalls (forwarding).
- Re-issue to the same rd while busy: the newer value overwrites the count (WAW keeps the youngest producer).
- id_rs==id_rd on the issuing instruction: hazard uses the pre-update count. The instruction never stalls on itself.
- Reset mid-stall: all counters clear and outputs fall combinationally to redirect-only values. No pending hazards survive reset.
- Outputs are combinational from state and inputs. After reset with all inputs 0, all outputs are 0.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined, three 32-bit saturating output counters are added, each reset to 0 and updated only when mem_stall=0:
  - perf_lu_stall: +1 per cycle with hz & ~id_early & ~redirect.
  - perf_br_stall: +1 per cycle with hz & id_early & ~redirect.
  - perf_flush: +1 per cycle with redirect.
- Counters stick at 32'hFFFFFFFF.
- When undefined, these ports and their logic are absent. Core behaviour is identical either way.

Test Plan:
- LD_LAT=1: issue load x5, next cycle add reading x5 -> stall=1 and bubble=1 for exactly 1 cycle; add issues on the 2nd cycle.
- LD_LAT=1: load x5, then beq on x5 (id_early=1) -> stall for 2 cycles, issue on the 3rd; an ALU producer followed by beq -> 1 stall.
- LD_LAT=3: load x7, then dependent ALU op -> 3 stall cycles; busy_vec[7] is high for 4 cycles after issue.
- Load x5 with a dependent op in ID; assert mem_stall for 4 cycles -> stall=1, bubble=0, cnt[5] frozen at 2. After release -> 1 bubble cycle, then issue.
- Hazard pending on x5 and redirect=1 in the same cycle -> flush=1, stall=0, bubble=1, no cnt write. Load writing x0 -> no tracking and no stall on x0 readers.
- HAZARD_PERF_EN: run the scenarios above -> perf_lu_stall=1, perf_br_stall=2, perf_flush=1. Preloaded 32'hFFFFFFFF -> stays saturated.
